// File: rtl/data_memory_responder_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
// The lane functions are also used by the CPU's load-extension logic.
package data_memory_responder_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_DONE
   } state_t;

   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [1:0] off
   );
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         SZ_WORD: return off != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_be(
      input logic [1:0] size,
      input logic [1:0] off
   );
      case (size)
         SZ_BYTE: return 4'b0001 << off;
         SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Replicates right-justified store data onto every lane; the
   // byte enables pick which copy lands in the word.
   function automatic logic [31:0] lane_merge(
      input logic [1:0]  size,
      input logic [31:0] wdata
   );
      case (size)
         SZ_BYTE: return {4{wdata[7:0]}};
         SZ_HALF: return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic [31:0] lane_extract(
      input logic [1:0]  size,
      input logic [1:0]  off,
      input logic [31:0] word
   );
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (size)
         SZ_BYTE: return {24'h0, sh[7:0]};
         SZ_HALF: return {16'h0, sh[15:0]};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_array.sv
// Single-port word array with byte write enables and registered read.
// No reset; contents start at zero.
module data_memory_array #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk_i,
   input  logic [3:0]            we_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   logic [31:0] mem_q [2**DEPTH_LOG2] = '{default: '0};
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Load/store responder: one request at a time, programmable wait
// states, lane-merged stores and zero-extended lane-extracted loads.
module data_memory_responder
   import data_memory_responder_pkg::*;
#(
   parameter int DATA_SIZE   = 32,
   parameter int ADDR_SIZE   = 32,
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Req,
   input  logic                 WriteEn,
   input  logic [1:0]           Size,
   input  logic [ADDR_SIZE-1:0] Address,
   input  logic [DATA_SIZE-1:0] WriteData,
   output logic [DATA_SIZE-1:0] ReadData,
   output logic                 Ready,
   output logic                 Error,
   output logic                 Busy
);

   localparam int AW = DEPTH_LOG2 + 2;
   localparam logic [3:0] WAIT_INIT =
      (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t         state_q;
   logic [3:0]     cnt_q;
   logic [AW-1:0]  addr_q;
   logic [1:0]     size_q;
   logic           we_q;
   logic [31:0]    wdata_q;
   logic [31:0]    rdata_q;
   logic           ready_q;
   logic           error_q;
   logic           busy_q;

   logic [DEPTH_LOG2-1:0] idx_d;
   logic [3:0]            be_d;
   logic [31:0]           wlane_d;
   logic [31:0]           arr_rdata;
   logic                  unused_addr;

   assign unused_addr = ^Address[ADDR_SIZE-1:AW];

   // The array reads every cycle; in IDLE it is pointed at the incoming
   // address so the word is already registered when ACCESS is reached.
   assign idx_d = (state_q == ST_IDLE) ? Address[AW-1:2]
                                       : addr_q[AW-1:2];
   assign be_d = (state_q == ST_ACCESS && we_q)
               ? lane_be(size_q, addr_q[1:0]) : 4'b0000;
   assign wlane_d = lane_merge(size_q, wdata_q);

   data_memory_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_array (
      .clk_i  (Clk),
      .we_i   (be_d),
      .addr_i (idx_d),
      .wdata_i(wlane_d),
      .rdata_o(arr_rdata)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         error_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (Req) begin
                  addr_q  <= Address[AW-1:0];
                  size_q  <= Size;
                  we_q    <= WriteEn;
                  wdata_q <= WriteData;
                  busy_q  <= 1'b1;
                  if (misaligned(Size, Address[1:0])) begin
                     state_q <= ST_DONE;
                     ready_q <= 1'b1;
                     error_q <= 1'b1;
                  end else if (WAIT_CYCLES == 0) begin
                     state_q <= ST_ACCESS;
                  end else begin
                     cnt_q   <= WAIT_INIT;
                     state_q <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_ACCESS;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_ACCESS: begin
               if (!we_q) begin
                  rdata_q <= lane_extract(size_q, addr_q[1:0],
                                          arr_rdata);
               end
               state_q <= ST_DONE;
               ready_q <= 1'b1;
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ReadData = rdata_q;
   assign Ready    = ready_q;
   assign Error    = error_q;
   assign Busy     = busy_q;

endmodule
